// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// General-purpose register file for the simple datapath CPU.
// One synchronous write port, two independent combinational read ports.
//
// Ports:
//   clk           rising-edge clock for all state changes
//   reset         asynchronous active-low clear of every register
//   write_enable  write register[write_index] with write_data on next edge
//   write_index   register to write
//   write_data    value to write
//   read_index_a  register selected for read port A
//   read_data_a   contents of register[read_index_a] (combinational)
//   read_index_b  register selected for read port B
//   read_data_b   contents of register[read_index_b] (combinational)
// ----------------------------------------------------------------------------
module reg_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_index,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_index_a,
   output logic [DATA_WIDTH-1:0] read_data_a,
   input  logic [ADDR_WIDTH-1:0] read_index_b,
   output logic [DATA_WIDTH-1:0] read_data_b
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

   always_comb begin
      regs_d = regs_q;
      if (write_enable) begin
         regs_d[write_index] = write_data;
      end
   end

   // Reset is asynchronous, so it clears storage immediately and also
   // overrides any write presented on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads come straight from the flops: no write-through bypass, so a
   // same-index write becomes visible only after the edge.
   assign read_data_a = regs_q[read_index_a];
   assign read_data_b = regs_q[read_index_b];

endmodule

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
// Directed self-checking bench for reg_file (DATA_WIDTH=16, ADDR_WIDTH=2).
// ----------------------------------------------------------------------------
module tb_reg_file;

   logic        clk;
   logic        reset;
   logic        write_enable;
   logic [1:0]  write_index;
   logic [15:0] write_data;
   logic [1:0]  read_index_a;
   logic [15:0] read_data_a;
   logic [1:0]  read_index_b;
   logic [15:0] read_data_b;

   int passed;
   int total;

   logic [15:0] tbl [4];

   reg_file #(
      .DATA_WIDTH(16),
      .ADDR_WIDTH(2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .write_enable(write_enable),
      .write_index (write_index),
      .write_data  (write_data),
      .read_index_a(read_index_a),
      .read_data_a (read_data_a),
      .read_index_b(read_index_b),
      .read_data_b (read_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
   endtask

   // Advance through one rising edge and settle 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      passed       = 0;
      total        = 0;
      reset        = 1'b1;
      write_enable = 1'b0;
      write_index  = '0;
      write_data   = '0;
      read_index_a = '0;
      read_index_b = '0;
      tbl[0] = 16'h0011;
      tbl[1] = 16'h0022;
      tbl[2] = 16'h0033;
      tbl[3] = 16'hFFFF;

      // Reset with no clock edge: every index reads 0 on both ports.
      #1 reset = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         read_index_a = 2'(i);
         read_index_b = 2'(3 - i);
         #0.5;
         check($sformatf("rst_a%0d", i), read_data_a, 16'h0000);
         check($sformatf("rst_b%0d", 3 - i), read_data_b, 16'h0000);
      end

      // Preload reg2 then pulse reset between edges.
      @(negedge clk);
      reset        = 1'b1;
      write_enable = 1'b1;
      write_index  = 2'd2;
      write_data   = 16'h1234;
      step();
      write_enable = 1'b0;
      read_index_a = 2'd2;
      #1 check("preload_r2", read_data_a, 16'h1234);
      reset = 1'b0;
      #1 check("async_clear_r2", read_data_a, 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      // Basic write/read.
      write_enable = 1'b1;
      write_index  = 2'd0;
      write_data   = 16'd3;
      read_index_a = 2'd1;
      #1 check("basic_r1_pre", read_data_a, 16'h0000);
      step();
      check("basic_r1_post", read_data_a, 16'h0000);
      write_index  = 2'd1;
      write_data   = 16'd7;
      read_index_a = 2'd0;
      #1 check("basic_r0", read_data_a, 16'd3);
      step();
      write_enable = 1'b0;
      read_index_a = 2'd1;
      #1 check("basic_r1", read_data_a, 16'd7);

      // Write disabled: nothing changes.
      write_index = 2'd0;
      write_data  = 16'd10;
      step();
      read_index_a = 2'd0;
      read_index_b = 2'd1;
      #1;
      check("wdis_r0", read_data_a, 16'd3);
      check("wdis_r1", read_data_b, 16'd7);

      // Read-during-write: old value before the edge, new value after.
      read_index_a = 2'd2;
      write_index  = 2'd2;
      write_data   = 16'hBEEF;
      write_enable = 1'b1;
      #1 check("rdw_before", read_data_a, 16'h0000);
      step();
      write_enable = 1'b0;
      check("rdw_after", read_data_a, 16'hBEEF);

      // Dual port: fill the table and sweep all 16 index pairs.
      for (int i = 0; i < 4; i++) begin
         write_enable = 1'b1;
         write_index  = 2'(i);
         write_data   = tbl[i];
         step();
      end
      write_enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            read_index_a = 2'(i);
            read_index_b = 2'(j);
            @(negedge clk);
            check($sformatf("dual_a%0d_b%0d_a", i, j), read_data_a, tbl[i]);
            check($sformatf("dual_a%0d_b%0d_b", i, j), read_data_b, tbl[j]);
         end
      end

      // Reset vs write in the same cycle: reset wins.
      write_enable = 1'b1;
      write_index  = 2'd3;
      write_data   = 16'd5;
      read_index_a = 2'd3;
      read_index_b = 2'd0;
      #2 reset = 1'b0;
      #1;
      check("rvw_during_r3", read_data_a, 16'h0000);
      check("rvw_during_r0", read_data_b, 16'h0000);
      step();
      check("rvw_edge_r3", read_data_a, 16'h0000);
      @(negedge clk);
      write_enable = 1'b0;
      reset        = 1'b1;
      #1 check("rvw_deassert_r3", read_data_a, 16'h0000);
      step();
      check("rvw_after_r3", read_data_a, 16'h0000);
      read_index_b = 2'd1;
      #1 check("rvw_after_r1", read_data_b, 16'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
